// File: rtl/stream_or_reducer_if.sv
// Handshake bundle for stream_or_reducer: upstream beat stream in, one reduced word out.
// With STREAM_OR_REDUCER_PARITY_EN defined, the bundle also carries down_parity.
interface stream_or_reducer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             up_last;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_data;
  logic [CNT_W-1:0] down_count;
`ifdef STREAM_OR_REDUCER_PARITY_EN
  logic             down_parity;
`endif

  // The environment: it produces beats and consumes results.
  modport master (
    output up_valid, up_data, up_last, down_ready,
    input  up_ready, down_valid, down_data, down_count
`ifdef STREAM_OR_REDUCER_PARITY_EN
    , input down_parity
`endif
  );

  // The reducer itself.
  modport slave (
    input  up_valid, up_data, up_last, down_ready,
    output up_ready, down_valid, down_data, down_count
`ifdef STREAM_OR_REDUCER_PARITY_EN
    , output down_parity
`endif
  );
endinterface

// File: rtl/stream_or_reducer.sv
// Reduces a multi-beat frame to one word by bitwise OR built from constant-1 muxes.
// Optional: STREAM_OR_REDUCER_PARITY_EN adds down_parity, the XOR of every bit of the frame.
module mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module stream_or_reducer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_or_reducer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] or_word;
  logic [WIDTH-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_valid_q;
  logic             accepting;
  logic             beat;
  logic             take;
  logic             ld_out;
`ifdef STREAM_OR_REDUCER_PARITY_EN
  logic             par_q, par_d;
  logic             out_par_q;
  logic             beat_par;
`endif

  // Gated by rst_n so the producer sees no ready while the block is held in reset.
  assign accepting = rst_n && (state_q != OUTPUT);
  assign beat      = bus.up_valid && accepting;
  assign take      = out_valid_q && bus.down_ready;

  // acc OR up_data: a set accumulator bit selects the constant 1, otherwise the beat bit passes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_or
    mux u_or (
      .a  (bus.up_data[i]),
      .b  (1'b1),
      .sel(acc_q[i]),
      .y  (or_word[i])
    );
  end

`ifdef STREAM_OR_REDUCER_PARITY_EN
  assign beat_par = ^bus.up_data;
`endif

  // NOTE: every signal this block writes gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ld_out  = 1'b0;
`ifdef STREAM_OR_REDUCER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d = bus.up_data;
          cnt_d = CNT_ONE;
`ifdef STREAM_OR_REDUCER_PARITY_EN
          par_d = beat_par;
`endif
          if (bus.up_last) begin
            state_d = OUTPUT;
            ld_out  = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (beat) begin
          acc_d = or_word;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
`ifdef STREAM_OR_REDUCER_PARITY_EN
          par_d = par_q ^ beat_par;
`endif
          if (bus.up_last) begin
            state_d = OUTPUT;
            ld_out  = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (take) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef STREAM_OR_REDUCER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
`ifdef STREAM_OR_REDUCER_PARITY_EN
        par_d   = 1'b0;
`endif
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef STREAM_OR_REDUCER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef STREAM_OR_REDUCER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Result registers load with the final combined value on the last beat and hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
`ifdef STREAM_OR_REDUCER_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else if (ld_out) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_d;
      out_count_q <= cnt_d;
`ifdef STREAM_OR_REDUCER_PARITY_EN
      out_par_q   <= par_d;
`endif
    end else if (take) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.up_ready   = accepting;
  assign bus.down_valid = out_valid_q;
  assign bus.down_data  = out_data_q;
  assign bus.down_count = out_count_q;
`ifdef STREAM_OR_REDUCER_PARITY_EN
  assign bus.down_parity = out_par_q;
`endif
endmodule

// File: tb/tb_stream_or_reducer.sv
// Scoreboard bench for stream_or_reducer: stimulus pushes expected results, a monitor pops on transfer.
// Build with STREAM_OR_REDUCER_PARITY_EN defined to also check down_parity.
module tb_stream_or_reducer;
  logic clk = 1'b0;
  logic rst_n;

  stream_or_reducer_if #(.WIDTH(8), .CNT_W(4)) bus ();

  stream_or_reducer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] count;
    logic       par;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] c, input logic p);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.par   = p;
    sb.push_back(e);
  endtask

  // Presents one beat and returns just after the edge that consumed it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    bus.up_last  = l;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.up_ready) break;
    end
    if (!bus.up_ready) check("beat_accept_timeout", {31'd0, bus.up_ready}, 32'd1);
    step();
    bus.up_valid = 1'b0;
    bus.up_data  = 'x;
    bus.up_last  = 'x;
  endtask

  // Monitor: compares every result at the negedge before the edge that transfers it.
  always @(negedge clk) begin
    if (rst_n && bus.down_valid) begin
      check("up_ready_in_output", {31'd0, bus.up_ready}, 32'd0);
      if (bus.down_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data %0h count %0d with empty scoreboard",
                   bus.down_data, bus.down_count);
        end else begin
          mon_e = sb.pop_front();
          check("sb_data", {24'd0, bus.down_data}, {24'd0, mon_e.data});
          check("sb_count", {28'd0, bus.down_count}, {28'd0, mon_e.count});
`ifdef STREAM_OR_REDUCER_PARITY_EN
          check("sb_parity", {31'd0, bus.down_parity}, {31'd0, mon_e.par});
`endif
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_last    = 1'b0;
    bus.down_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_down_valid", {31'd0, bus.down_valid}, 32'd0);
    check("rst_up_ready", {31'd0, bus.up_ready}, 32'd0);
    check("rst_down_data", {24'd0, bus.down_data}, 32'd0);
    check("rst_down_count", {28'd0, bus.down_count}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_up_ready", {31'd0, bus.up_ready}, 32'd1);

    // Single-beat frame, latency 1
    bus.down_ready = 1'b1;
    check("t1_pre_valid", {31'd0, bus.down_valid}, 32'd0);
    push(8'hA5, 4'd1, 1'b0);
    send_beat(8'hA5, 1'b1);
    check("t1_valid_lat1", {31'd0, bus.down_valid}, 32'd1);
    check("t1_data", {24'd0, bus.down_data}, 32'hA5);
    check("t1_count", {28'd0, bus.down_count}, 32'd1);
    step();
    check("t1_done_valid", {31'd0, bus.down_valid}, 32'd0);
    check("t1_idle_ready", {31'd0, bus.up_ready}, 32'd1);

    // Frame with gaps between beats
    push(8'h91, 4'd3, 1'b1);
    send_beat(8'h01, 1'b0);
    idle(2);
    send_beat(8'h10, 1'b0);
    idle(1);
    send_beat(8'h80, 1'b1);
    step();
    check("t2_done_valid", {31'd0, bus.down_valid}, 32'd0);

    // Backpressure with a beat waiting upstream
    bus.down_ready = 1'b0;
    push(8'hFF, 4'd2, 1'b0);
    push(8'h33, 4'd1, 1'b0);
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b1);
    bus.up_valid = 1'b1;
    bus.up_data  = 8'h33;
    bus.up_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, bus.down_valid}, 32'd1);
      check("t3_hold_data", {24'd0, bus.down_data}, 32'hFF);
      check("t3_hold_count", {28'd0, bus.down_count}, 32'd2);
      check("t3_hold_ready", {31'd0, bus.up_ready}, 32'd0);
      step();
    end
    bus.down_ready = 1'b1;
    step();
    check("t3_taken_valid", {31'd0, bus.down_valid}, 32'd0);
    check("t3_ready_back", {31'd0, bus.up_ready}, 32'd1);
    step();
    bus.up_valid = 1'b0;
    check("t3_beat33_valid", {31'd0, bus.down_valid}, 32'd1);
    check("t3_beat33_data", {24'd0, bus.down_data}, 32'h33);
    step();

    // Count saturation over 20 zero beats
    push(8'h00, 4'd15, 1'b0);
    for (int i = 0; i < 20; i++) send_beat(8'h00, (i == 19));
    step();

    // Async reset mid-frame, then mid-OUTPUT
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    #3 rst_n = 1'b0;
    #1 check("t5a_rst_valid", {31'd0, bus.down_valid}, 32'd0);
    check("t5a_rst_ready", {31'd0, bus.up_ready}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    bus.down_ready = 1'b0;
    send_beat(8'h55, 1'b1);
    check("t5b_pending_valid", {31'd0, bus.down_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1 check("t5b_rst_valid", {31'd0, bus.down_valid}, 32'd0);
    check("t5b_rst_data", {24'd0, bus.down_data}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    bus.down_ready = 1'b1;
    push(8'h02, 4'd1, 1'b1);
    send_beat(8'h02, 1'b1);
    check("t5_fresh_data", {24'd0, bus.down_data}, 32'h02);
    check("t5_fresh_count", {28'd0, bus.down_count}, 32'd1);
    step();

    // Back-to-back single-beat frames
    push(8'h40, 4'd1, 1'b1);
    push(8'h04, 4'd1, 1'b1);
    send_beat(8'h40, 1'b1);
    send_beat(8'h04, 1'b1);

    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_or_reducer.md
Name: stream_or_reducer

Overview:
- Sequential front-end that feeds the mux-based OR gate path. It reduces a multi-beat stream to a single word by bitwise OR across every beat of a frame.
- The upstream producer sends beats over a valid/ready handshake and marks the end of a frame with a last flag.
- One result word per frame goes downstream over a second valid/ready handshake, with a beat count.
- The bitwise OR combine is built from instances of the existing mux module with constant 1 (one mux per bit); the `|` operator is not used.

Parameters:
- WIDTH, 8: data width of each beat and of the result.
- CNT_W, 4: width of the beat counter; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- up_valid  input  1  upstream beat valid.
- up_ready  output  1  block can accept a beat.
- up_data  input  WIDTH  beat data.
- up_last  input  1  final beat of the frame.
- down_valid  output  1  result valid.
- down_ready  input  1  downstream accepts the result.
- down_data  output  WIDTH  OR of all beats in the frame.
- down_count  output  CNT_W  number of beats in the frame, saturating.

Behaviour:
- One clock; reset is asynchronous and active-low. Asserting rst_n low sets, immediately and regardless of clk:
  - state = IDLE, up_ready = 0 while in reset
  - down_valid = 0, down_data = 0, down_count = 0
  - accumulator and counter = 0
- up_ready is combinational: 1 in IDLE and COLLECT, 0 in OUTPUT. It does not depend on down_ready.
- A beat transfers when up_valid && up_ready at a rising edge. up_data and up_last are ignored, and may be X, when up_valid = 0.
- IDLE, on a beat:
  - acc <= up_data; cnt <= 1.
  - If up_last: go to OUTPUT. Otherwise go to COLLECT.
- COLLECT, on a beat:
  - acc <= acc OR up_data.
  - cnt <= cnt+1, holding at 2^CNT_W-1 once reached (no wrap).
  - If up_last: go to OUTPUT. Otherwise stay in COLLECT.
- COLLECT, no beat: hold all state. There is no timeout.
- OUTPUT:
  - down_valid = 1; down_data = acc; down_count = cnt.
  - All outputs stay stable until the transfer.
  - On down_valid && down_ready: go to IDLE, and clear acc and cnt to 0.
- down_valid, down_data and down_count are registered outputs. The output value is valid in the cycle after the last beat is accepted (latency 1).
- Throughput:
  - Minimum L+1 cycles per L-beat frame.
  - A single-beat frame occupies 2 cycles: IDLE then OUTPUT.
- In OUTPUT, down_valid must not drop, and the output values must not change, until the transfer.
- down_ready high outside OUTPUT has no effect.
- If rst_n goes low mid-frame or mid-OUTPUT, the partial frame or pending result is discarded with no output. After reset release, the next beat starts a fresh frame in IDLE.
- All-zero beats give down_data = 0.
- Once any result bit becomes 1, it stays 1 until the frame completes.

Optional Feature:
- Macro: STREAM_OR_REDUCER_PARITY_EN.
- Defined:
  - Adds output port down_parity, 1 bit: XOR of all bits of all beats in the frame.
  - Accumulated alongside acc and cleared identically.
  - Registered with the same timing and stability rules as down_data.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single beat 0xA5 with last; down_ready = 1 → down_valid is 1 exactly one cycle after the beat, down_data = 0xA5, down_count = 1; parity = 0 if enabled. Returns to IDLE.
- Frame 0x01, 0x10, 0x80 (last), with up_valid gaps between beats → down_data = 0x91, down_count = 3. up_ready is 0 for the whole time down_valid is 1.
- Backpressure: hold down_ready = 0 for 5 cycles after the frame 0x0F, 0xF0 (last) → down_valid, down_data = 0xFF and down_count = 2 stay stable. up_ready stays 0, and a presented beat 0x33 is not consumed until one cycle after down_ready rises.
- Saturation with CNT_W = 4: a 20-beat frame of 0x00 → down_data = 0x00, down_count = 15.
- Async reset: drop rst_n mid-clock after 2 beats of 0xFF (no last) → down_valid goes to 0 immediately. After release, a frame of 0x02 (last) gives down_data = 0x02, down_count = 1.
- Back-to-back frames: 0x40 (last), then 0x04 (last) presented while the first result is accepted → two results, 0x40 then 0x04, each with count 1 and no merging.
